// File: rtl/platform_pkg.sv
`default_nettype none
// ============================================================================
// Module      : platform_pkg
// Description : Shared types, screen constants, LFSR seed/taps and the
//               reset coordinate tables for the platform game-state engine.
// Revision    : 1.0 - initial release
// ============================================================================
package platform_pkg;

    typedef logic [9:0] coord_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_SCAN = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    localparam int          C_NUM_PLAT_DEF    = 16;
    localparam int          C_SCREEN_H_DEF    = 480;
    localparam int          C_X_MIN_DEF       = 64;
    localparam int          C_SCROLL_LINE_DEF = 200;
    localparam int          C_MAX_SCROLL_DEF  = 8;
    localparam int          C_PLAT_HW_DEF     = 4;
    localparam int          C_PLAT_HH_DEF     = 4;
    localparam logic [15:0] C_LFSR_SEED       = 16'hACE1;

    // Fibonacci LFSR, taps 16,15,13,4 (bits 15,14,12,3), shifting left.
    function automatic logic [15:0] lfsr_next(input logic [15:0] v);
        return {v[14:0], v[15] ^ v[14] ^ v[12] ^ v[3]};
    endfunction

    function automatic coord_t reset_x(input int i, input int xmin);
        return coord_t'(xmin + ((i * 97) & 511));
    endfunction

    function automatic coord_t reset_y(input int i);
        return coord_t'(i * 30);
    endfunction

endpackage
`default_nettype wire

// File: rtl/platform_lfsr.sv
`default_nettype none
// ============================================================================
// Module      : platform_lfsr
// Description : 16-bit Fibonacci LFSR with load-on-reset seed and enable.
//               Exposes only the low OUT_W bits consumed by the caller.
// Ports       : clk, rst (async, active-high), i_seed (reset value),
//               i_en (advance), o_value (low OUT_W bits of the state)
// Revision    : 1.0 - initial release
// ============================================================================
module platform_lfsr
    import platform_pkg::*;
#(
    parameter int OUT_W = 9
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [15:0]      i_seed,
    input  logic             i_en,
    output logic [OUT_W-1:0] o_value
);

    logic [15:0] r_lfsr;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_lfsr <= i_seed;
        end else if (i_en) begin
            r_lfsr <= lfsr_next(r_lfsr);
        end
    end

    assign o_value = r_lfsr[OUT_W-1:0];

endmodule
`default_nettype wire

// File: rtl/platform_manager.sv
`default_nettype none
// ============================================================================
// Module      : platform_manager
// Description : Per-frame platform engine. On each frame strobe it scrolls
//               the platform slots, respawns slots falling off the bottom,
//               tests for ball landing and publishes a frame-stable set.
// Ports       : Clk, Reset (async, active-high), frame_clk (async strobe),
//               BallX/BallY/Ball_size/ball_falling (ball state),
//               PlatX/PlatY (published coords, 10 bits per slot),
//               scroll_amt, land, land_y, score, done, overrun
// Revision    : 1.0 - initial release
// ============================================================================
module platform_manager
    import platform_pkg::*;
#(
    parameter int NUM_PLAT    = C_NUM_PLAT_DEF,
    parameter int SCREEN_H    = C_SCREEN_H_DEF,
    parameter int X_MIN       = C_X_MIN_DEF,
    parameter int SCROLL_LINE = C_SCROLL_LINE_DEF,
    parameter int MAX_SCROLL  = C_MAX_SCROLL_DEF,
    parameter int PLAT_HW     = C_PLAT_HW_DEF,
    parameter int PLAT_HH     = C_PLAT_HH_DEF
) (
    input  logic                  Clk,
    input  logic                  Reset,
    input  logic                  frame_clk,
    input  logic [9:0]            BallX,
    input  logic [9:0]            BallY,
    input  logic [9:0]            Ball_size,
    input  logic                  ball_falling,
    output logic [10*NUM_PLAT-1:0] PlatX,
    output logic [10*NUM_PLAT-1:0] PlatY,
    output logic [3:0]            scroll_amt,
    output logic                  land,
    output logic [9:0]            land_y,
    output logic [15:0]           score,
    output logic                  done,
    output logic                  overrun
);

    localparam int              C_KW          = (NUM_PLAT > 1) ? $clog2(NUM_PLAT) : 1;
    localparam logic [C_KW-1:0] C_K_LAST      = C_KW'(NUM_PLAT - 1);
    localparam logic [10:0]     C_SCREEN_H    = 11'(SCREEN_H);
    localparam logic [10:0]     C_HW          = 11'(PLAT_HW);
    localparam logic [10:0]     C_HH          = 11'(PLAT_HH);
    localparam coord_t          C_HH10        = 10'(PLAT_HH);
    localparam coord_t          C_X_MIN       = 10'(X_MIN);
    localparam coord_t          C_SCROLL_LINE = 10'(SCROLL_LINE);
    localparam coord_t          C_MAX_S10     = 10'(MAX_SCROLL);
    localparam logic [3:0]      C_MAX_S4      = 4'(MAX_SCROLL);

    // frame_clk synchroniser and rising-edge detect
    logic r_fs1, r_fs2, r_fs3;
    logic w_tick;

    state_t r_state, w_next;

    logic [8:0] w_rnd;

    coord_t r_bx, r_by, r_bs;
    logic   r_bfall;
    logic [3:0] r_s;
    logic [C_KW-1:0] r_k;
    logic   r_found;
    coord_t r_ly_work;

    logic [10*NUM_PLAT-1:0] r_wx, r_wy;
    logic [10*NUM_PLAT-1:0] r_px, r_py;
    logic [3:0]  r_scroll;
    logic        r_land, r_done, r_overrun;
    coord_t      r_land_y;
    logic [15:0] r_score;

    // per-slot datapath
    int unsigned w_base;
    coord_t      w_cur_x, w_cur_y, w_upd_x, w_upd_y, w_ly_cand;
    logic [10:0] w_ny;
    logic        w_wrap, w_hit;
    logic [10:0] w_bx, w_by, w_bs, w_x11, w_y11;
    coord_t      w_diff;
    logic [3:0]  w_s_calc;

    platform_lfsr #(
        .OUT_W (9)
    ) u_lfsr (
        .clk     (Clk),
        .rst     (Reset),
        .i_seed  (C_LFSR_SEED),
        .i_en    (1'b1),
        .o_value (w_rnd)
    );

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            r_fs1 <= 1'b0;
            r_fs2 <= 1'b0;
            r_fs3 <= 1'b0;
        end else begin
            r_fs1 <= frame_clk;
            r_fs2 <= r_fs1;
            r_fs3 <= r_fs2;
        end
    end

    assign w_tick = r_fs2 & ~r_fs3;

    // ------------------------------------------------------------------ FSM
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE: if (w_tick) w_next = ST_CALC;
            ST_CALC: w_next = ST_SCAN;
            ST_SCAN: if (r_k == C_K_LAST) w_next = ST_DONE;
            ST_DONE: w_next = ST_IDLE;
            default: w_next = ST_IDLE;
        endcase
    end

    // ----------------------------------------------------- scroll amount
    always_comb begin
        w_s_calc = 4'd0;
        w_diff   = C_SCROLL_LINE - r_by;
        if (r_by < C_SCROLL_LINE) begin
            w_s_calc = (w_diff > C_MAX_S10) ? C_MAX_S4 : w_diff[3:0];
        end
    end

    // ----------------------------------------- slot update and landing test
    assign w_base  = 10 * 32'(r_k);
    assign w_cur_x = r_wx[w_base +: 10];
    assign w_cur_y = r_wy[w_base +: 10];
    assign w_ny    = {1'b0, w_cur_y} + {7'd0, r_s};
    assign w_wrap  = (w_ny >= C_SCREEN_H);
    assign w_upd_y = w_wrap ? 10'(w_ny - C_SCREEN_H) : w_ny[9:0];
    assign w_upd_x = w_wrap ? (C_X_MIN + {1'b0, w_rnd}) : w_cur_x;

    // Landing uses the post-update coordinates, all sums kept non-negative.
    assign w_bx  = {1'b0, r_bx};
    assign w_by  = {1'b0, r_by};
    assign w_bs  = {1'b0, r_bs};
    assign w_x11 = {1'b0, w_upd_x};
    assign w_y11 = {1'b0, w_upd_y};
    assign w_hit = r_bfall
                && (w_bx + w_bs + C_HW >= w_x11)
                && (w_x11 + C_HW + w_bs >= w_bx)
                && (w_by + w_bs + C_HH >= w_y11)
                && (w_y11 + C_HH >= w_by + w_bs);
    assign w_ly_cand = (w_upd_y >= C_HH10) ? (w_upd_y - C_HH10) : 10'd0;

    // ------------------------------------------------------------ datapath
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            for (int i = 0; i < NUM_PLAT; i++) begin
                r_wx[i*10 +: 10] <= reset_x(i, X_MIN);
                r_wy[i*10 +: 10] <= reset_y(i);
                r_px[i*10 +: 10] <= reset_x(i, X_MIN);
                r_py[i*10 +: 10] <= reset_y(i);
            end
            r_bx      <= '0;
            r_by      <= '0;
            r_bs      <= '0;
            r_bfall   <= 1'b0;
            r_s       <= '0;
            r_k       <= '0;
            r_found   <= 1'b0;
            r_ly_work <= '0;
            r_scroll  <= '0;
            r_land    <= 1'b0;
            r_land_y  <= '0;
            r_score   <= '0;
            r_done    <= 1'b0;
            r_overrun <= 1'b0;
        end else begin
            r_done <= 1'b0;
            r_land <= 1'b0;
            // A tick arriving mid-frame is dropped; remember that it happened.
            if (w_tick && (r_state != ST_IDLE)) begin
                r_overrun <= 1'b1;
            end
            case (r_state)
                ST_IDLE: begin
                    if (w_tick) begin
                        r_bx    <= BallX;
                        r_by    <= BallY;
                        r_bs    <= Ball_size;
                        r_bfall <= ball_falling;
                    end
                end
                ST_CALC: begin
                    r_s     <= w_s_calc;
                    r_k     <= '0;
                    r_found <= 1'b0;
                end
                ST_SCAN: begin
                    r_wx[w_base +: 10] <= w_upd_x;
                    r_wy[w_base +: 10] <= w_upd_y;
                    if (w_wrap && (r_score != 16'hFFFF)) begin
                        r_score <= r_score + 16'd1;
                    end
                    // Lowest-index match wins.
                    if (w_hit && !r_found) begin
                        r_found   <= 1'b1;
                        r_ly_work <= w_ly_cand;
                    end
                    r_k <= r_k + C_KW'(1);
                end
                ST_DONE: begin
                    r_px     <= r_wx;
                    r_py     <= r_wy;
                    r_scroll <= r_s;
                    r_done   <= 1'b1;
                    r_land   <= r_found;
                    if (r_found) begin
                        r_land_y <= r_ly_work;
                    end
                end
                default: ;
            endcase
        end
    end

    assign PlatX      = r_px;
    assign PlatY      = r_py;
    assign scroll_amt = r_scroll;
    assign land       = r_land;
    assign land_y     = r_land_y;
    assign score      = r_score;
    assign done       = r_done;
    assign overrun    = r_overrun;

endmodule
`default_nettype wire
